// File: rtl/oam_dma_arbiter.sv
// Shared cpu/DMA bus arbiter with a page-copy DMA sequencer.
// The cpu passes straight through when idle; a trigger write hands the bus to the DMA until the page is copied.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DMA_TARGET_ADDR  = 16'h2004,
  parameter int unsigned TRANSFER_LENGTH  = 256
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        tick_i,
  input  logic [15:0] cpu_address_i,
  input  logic        cpu_address_valid_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_data_valid_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_valid_o,
  output logic        cpu_ready_o,
  output logic [15:0] bus_address_o,
  output logic        bus_address_valid_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_valid_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_data_valid_i,
  output logic        dma_busy_o
);

  localparam int unsigned INDEX_W    = 9;
  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(TRANSFER_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t               state;
  logic [7:0]           page;
  logic [INDEX_W-1:0]   index;
  logic [7:0]           latch;
  logic                 parity;

  logic                 trigger_c;
  logic [15:0]          read_addr_c;

  assign trigger_c   = cpu_address_valid_i & cpu_data_valid_i & (cpu_address_i == DMA_TRIGGER_ADDR);
  assign read_addr_c = {page, 8'h00} + {7'h00, index};

  // Sequencer state; everything except reset advances only on a cpu tick.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state  <= S_IDLE;
      page   <= 8'h00;
      index  <= '0;
      latch  <= 8'h00;
      parity <= 1'b0;
    end else if (tick_i) begin
      parity <= ~parity;
      case (state)
        S_IDLE: begin
          if (trigger_c) begin
            page  <= cpu_data_i;
            index <= '0;
            state <= S_HALT;
          end
        end
        S_HALT:  state <= parity ? S_ALIGN : S_READ;
        S_ALIGN: state <= S_READ;
        S_READ: begin
          if (bus_data_valid_i) begin
            latch <= bus_data_i;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (index == LAST_INDEX) begin
            state <= S_IDLE;
          end else begin
            index <= index + INDEX_W'(1);
            state <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus/cpu steering: passthrough when idle (or held in reset), DMA-owned otherwise.
  always_comb begin
    cpu_data_o          = 8'h00;
    cpu_data_valid_o    = 1'b0;
    cpu_ready_o         = 1'b0;
    bus_address_o       = 16'h0000;
    bus_address_valid_o = 1'b0;
    bus_data_o          = 8'h00;
    bus_data_valid_o    = 1'b0;
    dma_busy_o          = 1'b1;
    if (reset_i || state == S_IDLE) begin
      cpu_data_o          = bus_data_i;
      cpu_data_valid_o    = bus_data_valid_i;
      cpu_ready_o         = 1'b1;
      bus_address_o       = cpu_address_i;
      bus_address_valid_o = cpu_address_valid_i;
      bus_data_o          = cpu_data_i;
      bus_data_valid_o    = cpu_data_valid_i;
      dma_busy_o          = 1'b0;
    end else if (state == S_READ) begin
      bus_address_o       = read_addr_c;
      bus_address_valid_o = 1'b1;
    end else if (state == S_WRITE) begin
      bus_address_o       = DMA_TARGET_ADDR;
      bus_address_valid_o = 1'b1;
      bus_data_o          = latch;
      bus_data_valid_o    = 1'b1;
    end
  end

endmodule
